// File: rtl/sample_sequencer.sv
// Sample-window sequencer for sample_register: counts pdm_in over a programmable window,
// pulses clear/store into the register and offers each finished sample with valid/ack.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start, all control outputs low
//   S_CLEAR | one cycle: clear sample_register, zero accumulator and tick
//   S_ACCUM | count pdm_in for period_q cycles
//   S_STORE | one cycle: write acc into sample_register, raise samp_valid
module sample_sequencer #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 16
) (
  input  logic             MHz10,
  input  logic             nrst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             pdm_in,
  output logic [ACC_W-1:0] samp_acc,
  output logic             reg_en,
  output logic             reg_clear,
  output logic             store_samp,
  output logic             samp_valid,
  input  logic             samp_ack,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ACCUM = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_tick;
  logic [CNT_W-1:0] r_period;
  logic [ACC_W-1:0] r_acc;
  logic             r_reg_en;
  logic             r_reg_clear;
  logic             r_store;
  logic             r_valid;
  logic             r_overrun;
  logic             r_busy;

  logic             w_last;
  logic [ACC_W-1:0] w_acc_next;

  assign w_last     = (r_tick == (r_period - CNT_W'(1)));
  assign w_acc_next = r_acc + ACC_W'(pdm_in);

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_period    <= CNT_W'(1);
      r_acc       <= '0;
      r_reg_en    <= 1'b0;
      r_reg_clear <= 1'b0;
      r_store     <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else if (en) begin
      // control strobes are one-cycle unless a transition below re-asserts them
      r_reg_en    <= 1'b0;
      r_reg_clear <= 1'b0;
      r_store     <= 1'b0;
      if (samp_ack) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_period    <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
            r_overrun   <= 1'b0;
            r_valid     <= 1'b0;
            r_reg_en    <= 1'b1;
            r_reg_clear <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          r_acc   <= '0;
          r_tick  <= '0;
          r_valid <= 1'b0;
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (stop) begin
            r_acc   <= '0;
            r_tick  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc  <= w_acc_next;
            r_tick <= r_tick + CNT_W'(1);
            if (w_last) begin
              r_reg_en <= 1'b1;
              r_store  <= 1'b1;
              r_state  <= S_STORE;
            end
          end
        end

        S_STORE: begin
          // an ack landing on the store cycle consumes the old sample, so no overrun
          if (r_valid && !samp_ack) r_overrun <= 1'b1;
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_tick  <= '0;
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ACCUM;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign samp_acc   = r_acc;
  assign reg_en     = r_reg_en & en;
  assign reg_clear  = r_reg_clear & en;
  assign store_samp = r_store & en;
  assign samp_valid = r_valid;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sample_sequencer.sv
// Scenario bench for sample_sequencer: expected stores (cycle, value) are queued when a
// window is launched and checked by a negedge monitor; each task checks its own outputs.
module tb_sample_sequencer;

  localparam int CNT_W = 16;
  localparam int ACC_W = 16;

  logic             MHz10 = 1'b0;
  logic             nrst;
  logic             en;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] cfg_period;
  logic             pdm_in;
  logic [ACC_W-1:0] samp_acc;
  logic             reg_en;
  logic             reg_clear;
  logic             store_samp;
  logic             samp_valid;
  logic             samp_ack;
  logic             overrun;
  logic             busy;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sample_sequencer #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .MHz10      (MHz10),
    .nrst       (nrst),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .cfg_period (cfg_period),
    .pdm_in     (pdm_in),
    .samp_acc   (samp_acc),
    .reg_en     (reg_en),
    .reg_clear  (reg_clear),
    .store_samp (store_samp),
    .samp_valid (samp_valid),
    .samp_ack   (samp_ack),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #50 MHz10 = ~MHz10;

  always @(posedge MHz10) cyc <= cyc + 1;

  // store monitor: every store_samp pulse must match the oldest queued expectation
  always @(negedge MHz10) begin
    if (nrst && store_samp) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_store: cyc=%0d samp_acc=%0d, required no store", cyc, samp_acc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc !== e.cyc || samp_acc !== ACC_W'(e.val)) begin
          n_bad++;
          $display("FAIL store: got cyc=%0d samp_acc=%0d, required cyc=%0d samp_acc=%0d",
                   cyc, samp_acc, e.cyc, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge MHz10);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; cfg_period = '0;
    pdm_in = 1'b0; samp_ack = 1'b0;
    #10;
    n_cmp++;
    if ({samp_acc, reg_en, reg_clear, store_samp, samp_valid, overrun, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got acc=%0d en/clr/st/vld/ovr/busy=%b%b%b%b%b%b, required all 0",
               samp_acc, reg_en, reg_clear, store_samp, samp_valid, overrun, busy);
    end
    run_to(2);
    @(negedge MHz10);
    nrst = 1'b1;
    step();
    n_cmp++;
    if ({busy, reg_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: got busy/reg_en=%b%b, required 00", busy, reg_en);
    end
  endtask

  task automatic test_basic_p4();
    int c;
    cfg_period = 16'd4; pdm_in = 1'b1;
    c = cyc;
    sb.push_back('{c + 6, 4});
    sb.push_back('{c + 11, 4});
    sb.push_back('{c + 16, 4});
    start = 1'b1; step(); start = 1'b0;
    n_cmp++;
    if ({reg_en, reg_clear, store_samp, busy} !== 4'b1101) begin
      n_bad++;
      $display("FAIL clear_cycle: got en/clr/st/busy=%b%b%b%b, required 1101",
               reg_en, reg_clear, store_samp, busy);
    end
    run_to(c + 7);
    n_cmp++;
    if ({samp_valid, overrun} !== 2'b10) begin
      n_bad++;
      $display("FAIL first_store_flags: got valid/overrun=%b%b, required 10", samp_valid, overrun);
    end
    run_to(c + 12);
    n_cmp++;
    if ({samp_valid, overrun} !== 2'b11) begin
      n_bad++;
      $display("FAIL overrun_set: got valid/overrun=%b%b, required 11", samp_valid, overrun);
    end
    run_to(c + 17);
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || samp_acc !== 16'd0) begin
      n_bad++;
      $display("FAIL stop_after_stores: got busy=%b acc=%0d, required busy=0 acc=0", busy, samp_acc);
    end
    run_to(c + 22);
  endtask

  task automatic test_pattern_p8();
    int c;
    bit pat[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cfg_period = 16'd8; pdm_in = 1'b0;
    c = cyc;
    sb.push_back('{c + 10, 4});
    start = 1'b1; step(); start = 1'b0;
    n_cmp++;
    if ({samp_valid, overrun, reg_clear} !== 3'b001) begin
      n_bad++;
      $display("FAIL start_clears_flags: got valid/overrun/clr=%b%b%b, required 001",
               samp_valid, overrun, reg_clear);
    end
    while (cyc < c + 12) begin
      if (cyc >= c + 2 && cyc <= c + 9) pdm_in = pat[cyc - c - 2];
      else pdm_in = 1'b1;
      samp_ack = (cyc == c + 11);
      stop     = (cyc == c + 11);
      step();
    end
    stop = 1'b0; samp_ack = 1'b0; pdm_in = 1'b0;
    n_cmp++;
    if ({busy, samp_valid, overrun} !== 3'b000 || samp_acc !== 16'd0) begin
      n_bad++;
      $display("FAIL ack_and_stop: got busy/valid/overrun=%b%b%b acc=%0d, required 000 acc=0",
               busy, samp_valid, overrun, samp_acc);
    end
  endtask

  task automatic test_period_zero();
    int c;
    bit pz[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    cfg_period = 16'd0;
    c = cyc;
    sb.push_back('{c + 3, 1});
    sb.push_back('{c + 5, 0});
    sb.push_back('{c + 7, 1});
    start = 1'b1; step(); start = 1'b0;
    while (cyc < c + 9) begin
      pdm_in   = pz[cyc - c];
      samp_ack = (cyc == c + 5) || (cyc == c + 7);
      stop     = (cyc == c + 8);
      if (cyc == c + 6) begin
        n_cmp++;
        if ({samp_valid, overrun} !== 2'b10) begin
          n_bad++;
          $display("FAIL ack_on_store: got valid/overrun=%b%b, required 10", samp_valid, overrun);
        end
      end
      step();
    end
    stop = 1'b0; samp_ack = 1'b0; pdm_in = 1'b0;
    n_cmp++;
    if ({busy, samp_valid, overrun} !== 3'b010) begin
      n_bad++;
      $display("FAIL p0_end_flags: got busy/valid/overrun=%b%b%b, required 010",
               busy, samp_valid, overrun);
    end
  endtask

  task automatic test_stop_mid();
    int c;
    cfg_period = 16'd10; pdm_in = 1'b1;
    c = cyc;
    start = 1'b1; step(); start = 1'b0;
    run_to(c + 7);
    n_cmp++;
    if (samp_acc !== 16'd5) begin
      n_bad++;
      $display("FAIL partial_acc: got samp_acc=%0d, required 5", samp_acc);
    end
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++;
    if ({busy, store_samp, reg_en} !== 3'b000 || samp_acc !== 16'd0) begin
      n_bad++;
      $display("FAIL stop_mid: got busy/st/en=%b%b%b acc=%0d, required 000 acc=0",
               busy, store_samp, reg_en, samp_acc);
    end
    run_to(c + 14);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    step();
    n_cmp++;
    if ({busy, reg_clear, reg_en} !== 3'b000) begin
      n_bad++;
      $display("FAIL start_stop_same: got busy/clr/en=%b%b%b, required 000", busy, reg_clear, reg_en);
    end
    pdm_in = 1'b0;
  endtask

  task automatic test_enable_gate();
    int c;
    cfg_period = 16'd6; pdm_in = 1'b1;
    c = cyc;
    sb.push_back('{c + 11, 6});
    sb.push_back('{c + 19, 6});
    start = 1'b1; step(); start = 1'b0;
    while (cyc < c + 21) begin
      en       = !((cyc >= c + 4 && cyc <= c + 6) || cyc == c + 18);
      stop     = (cyc == c + 5) || (cyc == c + 20);
      samp_ack = (cyc == c + 5) || (cyc == c + 18);
      start    = (cyc == c + 6);
      #1;
      if (cyc == c + 5) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL frozen_busy: got busy=%b, required 1", busy);
        end
      end
      if (cyc == c + 18) begin
        n_cmp++;
        if ({store_samp, reg_en} !== 2'b00 || samp_acc !== 16'd6) begin
          n_bad++;
          $display("FAIL en_gates_ctrl: got st/en=%b%b acc=%0d, required 00 acc=6",
                   store_samp, reg_en, samp_acc);
        end
      end
      step();
    end
    en = 1'b1; stop = 1'b0; samp_ack = 1'b0; start = 1'b0; pdm_in = 1'b0;
    n_cmp++;
    if ({busy, samp_valid, overrun} !== 3'b011) begin
      n_bad++;
      $display("FAIL ack_ignored_when_off: got busy/valid/overrun=%b%b%b, required 011",
               busy, samp_valid, overrun);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    cfg_period = 16'd10; pdm_in = 1'b1;
    c = cyc;
    start = 1'b1; step(); start = 1'b0;
    run_to(c + 5);
    #20;
    nrst = 1'b0;
    #1;
    n_cmp++;
    if ({samp_acc, reg_en, reg_clear, store_samp, samp_valid, overrun, busy} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got acc=%0d en/clr/st/vld/ovr/busy=%b%b%b%b%b%b, required all 0",
               samp_acc, reg_en, reg_clear, store_samp, samp_valid, overrun, busy);
    end
    step();
    @(negedge MHz10);
    nrst = 1'b1;
    step();
    cfg_period = 16'd2;
    c = cyc;
    sb.push_back('{c + 4, 2});
    start = 1'b1; step(); start = 1'b0;
    run_to(c + 5);
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++;
    if ({busy, samp_valid, overrun} !== 3'b010) begin
      n_bad++;
      $display("FAIL restart_after_reset: got busy/valid/overrun=%b%b%b, required 010",
               busy, samp_valid, overrun);
    end
    pdm_in = 1'b0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_p4();
    test_pattern_p8();
    test_period_zero();
    test_stop_mid();
    test_enable_gate();
    test_reset_mid();
    step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_stores: got %0d stores still pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
